z80_bus_mem: RTL

//  Synthesisable Z80 bus-side memory responder; replaces a constant-driven data bus in the

---
 rtl/z80_bus_mem_if.sv | 25 ++
 rtl/z80_bus_mem.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/z80_bus_mem_if.sv
// Z80 pin-side bus bundle between the CPU core and the bus memory responder.
interface z80_bus_mem_if;
  logic [15:0] addr_bus;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        MREQ_L;
  logic        IORQ_L;
  logic        RD_L;
  logic        WR_L;
  logic        RFSH_L;
  logic        WAIT_L;

  // CPU side: drives address, strobes and write data; sees read data and WAIT_L.
  modport master (
    output addr_bus, data_in, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L,
    input  data_out, data_oe, WAIT_L
  );

  // Memory side: decodes strobes, returns read data and inserts wait states.
  modport slave (
    input  addr_bus, data_in, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L,
    output data_out, data_oe, WAIT_L
  );
endinterface

// File: rtl/z80_bus_mem.sv
// Z80 bus-side memory responder: DEPTH x 8 array behind MREQ_L/RD_L/WR_L cycles,
// programmable WAIT_L insertion and a preload port that works in any state.
// Optional feature macro: Z80_BUS_MEM_IO_REG_EN adds one 8-bit I/O register at IO_PORT.
module z80_bus_mem #(
  parameter int unsigned DEPTH       = 4096,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [7:0]  OOR_DATA    = 8'hFF,
  parameter logic [7:0]  IO_PORT     = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  z80_bus_mem_if.slave      bus,
  input  logic              ld_en,
  input  logic [15:0]       ld_addr,
  input  logic [7:0]        ld_data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] WS = CW'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t        state;
  logic [15:0]   addr_q;
  logic          rd_q;
  logic          io_q;
  logic [CW-1:0] cnt;
  logic [7:0]    mem [DEPTH];

  logic          start_mem_c;
  logic          start_io_c;
  logic          req_held_c;
  logic          addr_ok_c;
  logic          ld_ok_c;
  logic          cpu_wr_c;
  logic [7:0]    rd_data_c;

  // Memory cycle start: refresh cycles never start an access.
  assign start_mem_c = !bus.MREQ_L && bus.RFSH_L && (!bus.RD_L || !bus.WR_L);

  assign addr_ok_c = 32'(addr_q)  < DEPTH;
  assign ld_ok_c   = 32'(ld_addr) < DEPTH;

  // CPU array write happens only in the ACCESS cycle; reset cancels it.
  assign cpu_wr_c = (state == S_ACCESS) && !rd_q && !io_q && addr_ok_c && !rst;

`ifdef Z80_BUS_MEM_IO_REG_EN
  logic [7:0] io_reg;
  logic       io_wr_c;

  // I/O cycle start: only the configured port, and only with a read or write strobe
  // (interrupt acknowledge carries IORQ_L without RD_L/WR_L and is ignored).
  assign start_io_c = !bus.IORQ_L && bus.MREQ_L && (bus.addr_bus[7:0] == IO_PORT) &&
                      (!bus.RD_L || !bus.WR_L);
  assign req_held_c = io_q ? !bus.IORQ_L : !bus.MREQ_L;
  assign io_wr_c    = (state == S_ACCESS) && !rd_q && io_q && !rst;
  assign rd_data_c  = io_q ? io_reg : (addr_ok_c ? mem[addr_q[AW-1:0]] : OOR_DATA);

  // I/O register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      io_reg <= 8'h00;
    end else if (io_wr_c) begin
      io_reg <= bus.data_in;
    end
  end
`else
  logic [8:0] unused_io;

  assign start_io_c = 1'b0;
  assign req_held_c = !bus.MREQ_L;
  assign rd_data_c  = addr_ok_c ? mem[addr_q[AW-1:0]] : OOR_DATA;
  assign unused_io  = {IO_PORT, bus.IORQ_L};
`endif

  // Storage: CPU write first, preload last so a same-address collision keeps ld_data.
  always_ff @(posedge clk) begin
    if (cpu_wr_c) begin
      mem[addr_q[AW-1:0]] <= bus.data_in;
    end
    if (ld_en && ld_ok_c) begin
      mem[ld_addr[AW-1:0]] <= ld_data;
    end
  end

  // Bus cycle FSM with registered WAIT_L / data_oe / data_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      addr_q       <= 16'h0000;
      rd_q         <= 1'b0;
      io_q         <= 1'b0;
      cnt          <= '0;
      bus.WAIT_L   <= 1'b1;
      bus.data_oe  <= 1'b0;
      bus.data_out <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_mem_c || start_io_c) begin
            addr_q <= bus.addr_bus;
            rd_q   <= !bus.RD_L;
            io_q   <= !start_mem_c;
            if (WS == '0) begin
              state <= S_ACCESS;
            end else begin
              state      <= S_WAIT;
              cnt        <= WS - CW'(1);
              bus.WAIT_L <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (!req_held_c) begin
            state      <= S_IDLE;
            bus.WAIT_L <= 1'b1;
          end else if (cnt == '0) begin
            state      <= S_ACCESS;
            bus.WAIT_L <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_ACCESS: begin
          if (rd_q) begin
            bus.data_out <= rd_data_c;
            bus.data_oe  <= 1'b1;
          end
          state <= S_HOLD;
        end
        S_HOLD: begin
          if (!req_held_c) begin
            bus.data_oe <= 1'b0;
            state       <= S_IDLE;
          end else if (bus.RD_L) begin
            bus.data_oe <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
